// File: rtl/wt_cache_pkg.sv
// Shared write-through cache types used by the dcache, the memory bridge and the adapters.
// Return-type helper lives here so every consumer classifies returns the same way.
package wt_cache_pkg;

    localparam int unsigned DCACHE_MAX_TX  = 4;
    localparam int unsigned CACHE_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        DCACHE_LOAD_REQ   = 2'd0,
        DCACHE_STORE_REQ  = 2'd1,
        DCACHE_ATOMIC_REQ = 2'd2
    } dcache_out_t;

    typedef enum logic [2:0] {
        DCACHE_INV_REQ    = 3'd0,
        DCACHE_LOAD_ACK   = 3'd1,
        DCACHE_STORE_ACK  = 3'd2,
        DCACHE_ATOMIC_ACK = 3'd3
    } dcache_in_t;

    typedef struct packed {
        dcache_out_t               rtype;
        logic [2:0]                size;
        logic [31:0]               paddr;
        logic [63:0]               data;
        logic [CACHE_ID_WIDTH-1:0] tid;
    } dcache_req_t;

    typedef struct packed {
        dcache_in_t                rtype;
        logic [63:0]               data;
        logic [CACHE_ID_WIDTH-1:0] tid;
    } dcache_rtrn_t;

    // True for returns that retire an earlier request.
    function automatic logic is_ack_rtrn(dcache_in_t rtype);
        logic ack;
        ack = 1'b0;
        case (rtype)
            DCACHE_LOAD_ACK,
            DCACHE_STORE_ACK,
            DCACHE_ATOMIC_ACK: ack = 1'b1;
            default:           ack = 1'b0;
        endcase
        return ack;
    endfunction

endpackage

// File: rtl/wt_dcache_mem_bridge_if.sv
// Bus bundle between the dcache memory port, the bridge and the memory adapter.
// slave is the bridge view; master is the dcache/adapter environment view.
interface wt_dcache_mem_bridge_if;
    import wt_cache_pkg::*;

    logic         dc_req_i;
    logic         dc_ack_o;
    dcache_req_t  dc_data_i;
    logic         mem_req_o;
    logic         mem_ack_i;
    dcache_req_t  mem_data_o;
    logic         mem_rtrn_vld_i;
    dcache_rtrn_t mem_rtrn_i;
    logic         dc_rtrn_vld_o;
    dcache_rtrn_t dc_rtrn_o;
    logic         idle_o;
    logic         err_o;

    modport slave (
        input  dc_req_i,
        input  dc_data_i,
        input  mem_ack_i,
        input  mem_rtrn_vld_i,
        input  mem_rtrn_i,
        output dc_ack_o,
        output mem_req_o,
        output mem_data_o,
        output dc_rtrn_vld_o,
        output dc_rtrn_o,
        output idle_o,
        output err_o
    );

    modport master (
        output dc_req_i,
        output dc_data_i,
        output mem_ack_i,
        output mem_rtrn_vld_i,
        output mem_rtrn_i,
        input  dc_ack_o,
        input  mem_req_o,
        input  mem_data_o,
        input  dc_rtrn_vld_o,
        input  dc_rtrn_o,
        input  idle_o,
        input  err_o
    );

endinterface

// File: rtl/wt_mem_bridge_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head is read combinationally.
// Push while full and pop while empty are ignored.
module wt_mem_bridge_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    T               mem_q [Depth];
    logic [PtrW:0]  wr_ptr_q;
    logic [PtrW:0]  rd_ptr_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
        end
    end

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/wt_dcache_mem_bridge.sv
// Decouples the dcache memory port from the adapter: request FIFO, credit
// counter bounding requests in flight, and a registered return path.
module wt_dcache_mem_bridge
    import wt_cache_pkg::*;
#(
    parameter int unsigned FifoDepth      = 2,
    parameter int unsigned MaxOutstanding = DCACHE_MAX_TX
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    wt_dcache_mem_bridge_if.slave  bus
);

    localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            rtrn_ack;
    logic            rtrn_dec;
    logic            rtrn_stray;
    logic [CntW-1:0] inflight_q;
    logic            err_q;
    logic            rtrn_vld_q;
    dcache_rtrn_t    rtrn_q;

    wt_mem_bridge_fifo #(
        .T     (dcache_req_t),
        .Depth (FifoDepth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (bus.dc_data_i),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (bus.mem_data_o)
    );

    // Credit check uses registered state only: a same-cycle return frees
    // its credit one cycle later.
    assign push = bus.dc_req_i & ~fifo_full & (inflight_q < MaxCnt);
    assign pop  = ~fifo_empty & bus.mem_ack_i;

    assign rtrn_ack   = bus.mem_rtrn_vld_i & is_ack_rtrn(bus.mem_rtrn_i.rtype);
    assign rtrn_dec   = rtrn_ack & (inflight_q != '0);
    assign rtrn_stray = rtrn_ack & (inflight_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
        end else if (push && !rtrn_dec) begin
            inflight_q <= inflight_q + CntW'(1);
        end else if (!push && rtrn_dec) begin
            inflight_q <= inflight_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (rtrn_stray) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rtrn_vld_q <= 1'b0;
            rtrn_q     <= '0;
        end else begin
            rtrn_vld_q <= bus.mem_rtrn_vld_i;
            if (bus.mem_rtrn_vld_i) rtrn_q <= bus.mem_rtrn_i;
        end
    end

    assign bus.dc_ack_o      = push;
    assign bus.mem_req_o     = ~fifo_empty;
    assign bus.dc_rtrn_vld_o = rtrn_vld_q;
    assign bus.dc_rtrn_o     = rtrn_q;
    assign bus.idle_o        = fifo_empty & (inflight_q == '0);
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_wt_dcache_mem_bridge.sv
// Bench for wt_dcache_mem_bridge: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wt_dcache_mem_bridge;
    import wt_cache_pkg::*;

    localparam int FD = 2;
    localparam int MO = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wt_dcache_mem_bridge_if bus();

    wt_dcache_mem_bridge #(
        .FifoDepth      (FD),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic dcache_req_t mk_req(input logic [2:0] tid);
        dcache_req_t r;
        r       = '0;
        r.rtype = DCACHE_STORE_REQ;
        r.size  = 3'd3;
        r.paddr = 32'h1000_0000 | {26'd0, tid, 3'd0};
        r.data  = 64'hA5A5_0000_0000_0000 | {61'd0, tid};
        r.tid   = tid;
        return r;
    endfunction

    function automatic dcache_rtrn_t mk_rtrn(input logic [2:0] rt, input logic [2:0] tid,
                                             input logic [63:0] d);
        dcache_rtrn_t r;
        r.rtype = dcache_in_t'(rt);
        r.data  = d;
        r.tid   = tid;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.dc_req_i       = 1'b0;
        bus.dc_data_i      = '0;
        bus.mem_ack_i      = 1'b0;
        bus.mem_rtrn_vld_i = 1'b0;
        bus.mem_rtrn_i     = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic set_in(input bit req, input logic [2:0] tid, input bit mack,
                          input bit rvld, input logic [2:0] rt);
        bus.dc_req_i       = req;
        bus.dc_data_i      = mk_req(tid);
        bus.mem_ack_i      = mack;
        bus.mem_rtrn_vld_i = rvld;
        bus.mem_rtrn_i     = mk_rtrn(rt, tid, 64'h5000 + 64'(rt));
    endtask

    typedef struct {
        bit         req;
        logic [2:0] tid;
        bit         mack;
        bit         rvld;
        logic [2:0] rt;
        bit         e_ack;
        bit         e_mreq;
        logic [2:0] e_mtid;
        bit         e_idle;
        bit         e_rvld;
    } vec_t;

    vec_t tbl[16];

    // reference model state
    dcache_req_t  q[$];
    int           infl;
    bit           err_m;
    bit           pv;
    dcache_rtrn_t pr;
    bit           cur_req;
    dcache_req_t  cur_d;

    initial begin
        // from reset: accept, FIFO full stall, credit limit, no credit bypass
        tbl[0]  = '{1, 3, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 1, 1, 3, 0, 0};
        tbl[3]  = '{1, 2, 0, 0, 0, 0, 1, 3, 0, 0};
        tbl[4]  = '{1, 2, 1, 0, 0, 0, 1, 3, 0, 0};
        tbl[5]  = '{1, 2, 0, 0, 0, 1, 1, 1, 0, 0};
        tbl[6]  = '{1, 4, 1, 0, 0, 0, 1, 1, 0, 0};
        tbl[7]  = '{1, 4, 1, 0, 0, 0, 1, 2, 0, 0};
        tbl[8]  = '{1, 4, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 4, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 1, 4, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 1, 2, 0, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 3, 0, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        do_reset();
        #2;
        chk("rst_ack",   128'(bus.dc_ack_o),      128'(0));
        chk("rst_mreq",  128'(bus.mem_req_o),     128'(0));
        chk("rst_rvld",  128'(bus.dc_rtrn_vld_o), 128'(0));
        chk("rst_idle",  128'(bus.idle_o),        128'(1));
        chk("rst_err",   128'(bus.err_o),         128'(0));
        chk("rst_rtrn",  128'(bus.dc_rtrn_o),     128'(0));
        tick();

        foreach (tbl[i]) begin
            set_in(tbl[i].req, tbl[i].tid, tbl[i].mack, tbl[i].rvld, tbl[i].rt);
            #2;
            chk($sformatf("v%0d_ack", i),  128'(bus.dc_ack_o),      128'(tbl[i].e_ack));
            chk($sformatf("v%0d_mreq", i), 128'(bus.mem_req_o),     128'(tbl[i].e_mreq));
            if (tbl[i].e_mreq)
                chk($sformatf("v%0d_mtid", i), 128'(bus.mem_data_o.tid), 128'(tbl[i].e_mtid));
            chk($sformatf("v%0d_idle", i), 128'(bus.idle_o),        128'(tbl[i].e_idle));
            chk($sformatf("v%0d_rvld", i), 128'(bus.dc_rtrn_vld_o), 128'(tbl[i].e_rvld));
            chk($sformatf("v%0d_err", i),  128'(bus.err_o),         128'(0));
            tick();
        end

        // invalidation passthrough
        do_reset();
        set_in(1, 5, 0, 0, 0); #2; chk("inv_acc", 128'(bus.dc_ack_o), 128'(1)); tick();
        set_in(0, 0, 1, 0, 0); #2; chk("inv_drn", 128'(bus.mem_req_o), 128'(1)); tick();
        idle_in();
        bus.mem_rtrn_vld_i = 1'b1;
        bus.mem_rtrn_i     = mk_rtrn(3'd0, 3'd5, 64'h11);
        tick();
        idle_in(); #2;
        chk("inv_fwd",  128'(bus.dc_rtrn_vld_o), 128'(1));
        chk("inv_pay",  128'(bus.dc_rtrn_o), 128'(mk_rtrn(3'd0, 3'd5, 64'h11)));
        chk("inv_idle", 128'(bus.idle_o), 128'(0));
        tick();
        set_in(0, 5, 0, 1, 2); tick();
        idle_in(); #2; chk("st_idle", 128'(bus.idle_o), 128'(1));
        tick();

        // simultaneous accept and atomic ack with one in flight
        set_in(1, 6, 0, 0, 0); tick();
        set_in(0, 0, 1, 0, 0); tick();
        idle_in();
        bus.dc_req_i       = 1'b1;
        bus.dc_data_i      = mk_req(3'd2);
        bus.mem_rtrn_vld_i = 1'b1;
        bus.mem_rtrn_i     = mk_rtrn(3'd3, 3'd1, 64'hDEAD_BEEF_0123_4567);
        #2; chk("sim_ack", 128'(bus.dc_ack_o), 128'(1));
        tick();
        set_in(0, 0, 1, 0, 0); #2;
        chk("sim_rvld", 128'(bus.dc_rtrn_vld_o), 128'(1));
        chk("sim_pay",  128'(bus.dc_rtrn_o), 128'(mk_rtrn(3'd3, 3'd1, 64'hDEAD_BEEF_0123_4567)));
        chk("sim_mtid", 128'(bus.mem_data_o.tid), 128'(2));
        tick();
        idle_in(); #2; chk("sim_busy", 128'(bus.idle_o), 128'(0));
        tick();
        set_in(0, 2, 0, 1, 1); tick();
        idle_in(); #2;
        chk("sim_idle", 128'(bus.idle_o), 128'(1));
        chk("sim_err",  128'(bus.err_o), 128'(0));
        tick();

        // stray return, then reset mid-stream
        set_in(0, 7, 0, 1, 1); tick();
        idle_in(); #2;
        chk("str_err",  128'(bus.err_o), 128'(1));
        chk("str_fwd",  128'(bus.dc_rtrn_vld_o), 128'(1));
        chk("str_tid",  128'(bus.dc_rtrn_o.tid), 128'(7));
        chk("str_idle", 128'(bus.idle_o), 128'(1));
        tick();
        set_in(1, 1, 0, 0, 0); #2; chk("str_nowrap", 128'(bus.dc_ack_o), 128'(1)); tick();
        set_in(1, 2, 0, 0, 0); #2; chk("str_acc2", 128'(bus.dc_ack_o), 128'(1)); tick();
        idle_in(); #2;
        chk("str_stick", 128'(bus.err_o), 128'(1));
        chk("pre_mreq",  128'(bus.mem_req_o), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("ar_mreq", 128'(bus.mem_req_o), 128'(0));
        chk("ar_idle", 128'(bus.idle_o), 128'(1));
        chk("ar_err",  128'(bus.err_o), 128'(0));
        tick();
        rst_n = 1'b1;

        // randomized traffic against the reference model
        do_reset();
        q.delete();
        infl    = 0;
        err_m   = 0;
        pv      = 0;
        pr      = '0;
        cur_req = 0;
        cur_d   = '0;
        for (int c = 0; c < 3000; c++) begin
            bit           e_ack;
            bit           qual;
            logic [2:0]   rt;
            dcache_rtrn_t rr;
            if (!cur_req && $urandom_range(0, 2) != 0) begin
                cur_req       = 1;
                cur_d.rtype   = dcache_out_t'($urandom_range(0, 2));
                cur_d.size    = 3'($urandom);
                cur_d.paddr   = $urandom;
                cur_d.data    = {$urandom, $urandom};
                cur_d.tid     = 3'($urandom);
            end
            rt       = 3'($urandom_range(0, 5));
            rr.rtype = dcache_in_t'(rt);
            rr.data  = {$urandom, $urandom};
            rr.tid   = 3'($urandom);
            bus.dc_req_i       = cur_req;
            bus.dc_data_i      = cur_d;
            bus.mem_ack_i      = 1'($urandom_range(0, 1));
            bus.mem_rtrn_vld_i = (infl == 0) ? ($urandom_range(0, 15) == 0)
                                             : ($urandom_range(0, 1) == 1);
            bus.mem_rtrn_i     = rr;
            #2;
            e_ack = cur_req && (q.size() < FD) && (infl < MO);
            chk("r_ack",  128'(bus.dc_ack_o), 128'(e_ack));
            chk("r_mreq", 128'(bus.mem_req_o), 128'(q.size() > 0));
            if (q.size() > 0) chk("r_head", 128'(bus.mem_data_o), 128'(q[0]));
            chk("r_idle", 128'(bus.idle_o), 128'(q.size() == 0 && infl == 0));
            chk("r_err",  128'(bus.err_o), 128'(err_m));
            chk("r_rvld", 128'(bus.dc_rtrn_vld_o), 128'(pv));
            if (pv) chk("r_rtrn", 128'(bus.dc_rtrn_o), 128'(pr));
            if (q.size() > 0 && bus.mem_ack_i) void'(q.pop_front());
            if (e_ack) begin
                q.push_back(cur_d);
                cur_req = 0;
            end
            qual = bus.mem_rtrn_vld_i && (rt >= 3'd1) && (rt <= 3'd3);
            if (qual) begin
                if (infl == 0) err_m = 1;
                else infl--;
            end
            if (e_ack) infl++;
            pv = bus.mem_rtrn_vld_i;
            if (pv) pr = rr;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
